sram_rw_cell: RTL and testbench



---
 rtl/sram_rw_pkg.sv | 18 +
 rtl/sram_rw_sense.sv | 71 +++++++
 rtl/sram_rw_cell.sv | 82 ++++++++
 tb/tb_sram_rw_cell.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sram_rw_pkg.sv
// ----------------------------------------------------------------------------
// sram_rw_pkg
// Shared constants and types for the sram_rw_cell array.
//   SRAM_RW_DEPTH : default number of stored words (power of two, >= 2)
//   SRAM_RW_WIDTH : default bits per word
//   sense_state_e : sense-amplifier phase (PRECHARGE = idle, EVALUATE = result)
// ----------------------------------------------------------------------------
package sram_rw_pkg;

    localparam int SRAM_RW_DEPTH = 16;
    localparam int SRAM_RW_WIDTH = 1;

    typedef enum logic {
        PRECHARGE = 1'b0,
        EVALUATE  = 1'b1
    } sense_state_e;

endpackage : sram_rw_pkg

// File: rtl/sram_rw_sense.sv
// ----------------------------------------------------------------------------
// sram_rw_sense
// Registered complementary sense stage. Captures a data word on an evaluate
// strobe and presents it as a true/complement pair; during precharge both
// rails are driven low and valid is low.
// Ports:
//   clk      in   sole clock, rising edge
//   reset    in   synchronous active-high reset (forces PRECHARGE)
//   i_eval   in   1 = evaluate i_data this edge, 0 = precharge
//   i_data   in   WIDTH  word to be sensed
//   o_out    out  WIDTH  complement rail (~data when valid, else 0)
//   o_out_b  out  WIDTH  true rail (data when valid, else 0)
//   o_valid  out  1 when the rails carry an evaluated result
// ----------------------------------------------------------------------------
module sram_rw_sense
    import sram_rw_pkg::*;
#(
    parameter int WIDTH = SRAM_RW_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_eval,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_out,
    output logic [WIDTH-1:0] o_out_b,
    output logic             o_valid
);

    sense_state_e     r_state;
    sense_state_e     w_state_nxt;
    logic [WIDTH-1:0] r_data;

    // State and data register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its inputs; blocking here would create order races.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PRECHARGE;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (i_eval) begin
                r_data <= i_data;
            end
        end
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = PRECHARGE;
        if (i_eval) begin
            w_state_nxt = EVALUATE;
        end
    end

    // Output decode purely from registered state: the rails are zero in
    // PRECHARGE and exact complements in EVALUATE by construction.
    always_comb begin
        o_out   = '0;
        o_out_b = '0;
        o_valid = 1'b0;
        if (r_state == EVALUATE) begin
            o_out   = ~r_data;
            o_out_b = r_data;
            o_valid = 1'b1;
        end
    end

endmodule : sram_rw_sense

// File: rtl/sram_rw_cell.sv
// ----------------------------------------------------------------------------
// sram_rw_cell
// DEPTH x WIDTH register-based SRAM model with a registered complementary
// sense output. Every wl=1 edge is an access (write with write-through when
// we=1, read otherwise); wl=0 edges precharge the outputs.
// Ports:
//   clk    in   sole clock, rising edge
//   reset  in   synchronous active-high reset, priority over wl/we
//   wl     in   word-line / access enable (0 = precharge cycle)
//   we     in   write enable, qualified by wl
//   addr   in   AW     word address
//   in     in   WIDTH  write data
//   out    out  WIDTH  complement-side sense output (registered)
//   out_b  out  WIDTH  true-side sense output (registered)
//   valid  out  1 when out/out_b carry an evaluated result
// Build option:
//   SRAM_RW_RESET_CLEAR_EN  when defined, reset also clears every cell to 0;
//                           otherwise reset leaves storage untouched.
// ----------------------------------------------------------------------------
module sram_rw_cell
    import sram_rw_pkg::*;
#(
    parameter int DEPTH = SRAM_RW_DEPTH,
    parameter int WIDTH = SRAM_RW_WIDTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wl,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_b,
    output logic             valid
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_en;
    logic [WIDTH-1:0] w_rd_data;

    assign w_wr_en = wl & we;

    // Write-through: a write presents the incoming data rather than the old
    // cell contents, so the sensed word equals what the cell now holds.
    assign w_rd_data = w_wr_en ? in : r_mem[addr];

    // Storage array. An X on wl/we makes the if-condition false in
    // simulation, so no write fires and no cell is disturbed.
`ifdef SRAM_RW_RESET_CLEAR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[addr] <= in;
        end
    end
`else
    // NOTE: the memory array is deliberately not reset so it maps onto plain
    // storage; reset only blocks a write that coincides with it.
    always_ff @(posedge clk) begin
        if (!reset && w_wr_en) begin
            r_mem[addr] <= in;
        end
    end
`endif

    sram_rw_sense #(
        .WIDTH (WIDTH)
    ) u_sense (
        .clk     (clk),
        .reset   (reset),
        .i_eval  (wl),
        .i_data  (w_rd_data),
        .o_out   (out),
        .o_out_b (out_b),
        .o_valid (valid)
    );

endmodule : sram_rw_cell

// File: tb/tb_sram_rw_cell.sv
// ----------------------------------------------------------------------------
// tb_sram_rw_cell
// Self-checking bench for sram_rw_cell: directed scenarios followed by
// randomized traffic, all compared against an array-based reference model.
// Honors SRAM_RW_RESET_CLEAR_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_sram_rw_cell;

    localparam int DEPTH = 16;
    localparam int WIDTH = 1;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             reset;
    logic             wl;
    logic             we;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] in_d;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_b;
    logic             valid;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: word contents plus whether each word is defined.
    logic [WIDTH-1:0] model_mem   [DEPTH];
    bit               model_known [DEPTH];

    sram_rw_cell #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .wl    (wl),
        .we    (we),
        .addr  (addr),
        .in    (in_d),
        .out   (out),
        .out_b (out_b),
        .valid (valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive on the falling edge, check 1 time unit after the
    // rising edge, then update the model.
    task automatic step(input logic rst, input logic w, input logic e,
                        input int a, input logic [WIDTH-1:0] d, input string tag);
        logic [WIDTH-1:0] all_ones;
        all_ones = '1;
        @(negedge clk);
        reset = rst;
        wl    = w;
        we    = e;
        addr  = a[AW-1:0];
        in_d  = d;
        @(posedge clk);
        #1;
        if (rst) begin
            check({tag, ":rst_valid"}, 32'(valid), 32'd0);
            check({tag, ":rst_out"},   32'(out),   32'd0);
            check({tag, ":rst_out_b"}, 32'(out_b), 32'd0);
`ifdef SRAM_RW_RESET_CLEAR_EN
            for (int i = 0; i < DEPTH; i++) begin
                model_mem[i]   = '0;
                model_known[i] = 1'b1;
            end
`endif
        end else if (!w) begin
            check({tag, ":pre_valid"}, 32'(valid), 32'd0);
            check({tag, ":pre_out"},   32'(out),   32'd0);
            check({tag, ":pre_out_b"}, 32'(out_b), 32'd0);
        end else if (e) begin
            check({tag, ":wr_valid"}, 32'(valid), 32'd1);
            check({tag, ":wr_out_b"}, 32'(out_b), 32'(d));
            check({tag, ":wr_out"},   32'(out),   32'(d ^ all_ones));
            model_mem[a]   = d;
            model_known[a] = 1'b1;
        end else begin
            check({tag, ":rd_valid"}, 32'(valid), 32'd1);
            if (model_known[a]) begin
                check({tag, ":rd_out_b"}, 32'(out_b), 32'(model_mem[a]));
                check({tag, ":rd_out"},   32'(out),   32'(model_mem[a] ^ all_ones));
            end else begin
                check({tag, ":rd_compl"}, 32'(out ^ out_b), 32'(all_ones));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i]   = '0;
            model_known[i] = 1'b0;
        end
        reset = 1'b1;
        wl    = 1'b0;
        we    = 1'b0;
        addr  = '0;
        in_d  = '0;

        // Reset for two cycles; with the clear option, addr 5 reads back 0.
        step(1, 0, 0, 0, 1'b0, "reset0");
        step(1, 1, 1, 5, 1'b1, "reset1");
`ifdef SRAM_RW_RESET_CLEAR_EN
        step(0, 1, 0, 5, 1'b0, "clr_rd5");
`endif

        // Write 3=1 with write-through, then read it back.
        step(0, 1, 1, 3, 1'b1, "wr3_1");
        step(0, 1, 0, 3, 1'b0, "rd3_1");

        // Write 3=0, precharge, read back.
        step(0, 1, 1, 3, 1'b0, "wr3_0");
        step(0, 0, 0, 3, 1'b1, "pre_a");
        step(0, 1, 0, 3, 1'b1, "rd3_0");

        // we ignored while wl=0: addr 7 keeps 0.
        step(0, 1, 1, 7, 1'b0, "wr7_0");
        step(0, 0, 1, 7, 1'b1, "pre_we7");
        step(0, 1, 0, 7, 1'b1, "rd7_0");

        // Back-to-back writes then reads, no bubbles.
        step(0, 1, 1, 1, 1'b1, "b2b_wr1");
        step(0, 1, 1, 2, 1'b0, "b2b_wr2");
        step(0, 1, 0, 1, 1'b0, "b2b_rd1");
        step(0, 1, 0, 2, 1'b1, "b2b_rd2");

        // Reset coincident with a write must not write.
        step(0, 1, 1, 4, 1'b0, "wr4_0");
        step(1, 1, 1, 4, 1'b1, "rst_wr4");
        step(0, 1, 0, 4, 1'b1, "rd4_0");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic r, w, e;
            int   a;
            logic [WIDTH-1:0] d;
            r = ($urandom_range(0, 49) == 0);
            w = ($urandom_range(0, 3) != 0);
            e = $urandom_range(0, 1) == 1;
            a = int'($urandom_range(0, DEPTH - 1));
            d = WIDTH'($urandom);
            step(r, w, e, a, d, "rand");
        end

        step(0, 0, 0, 0, 1'b0, "idle_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_sram_rw_cell
